// File: rtl/l1_backing_mem.sv
// Word-addressed backing memory for pico_L1 with a dual-push write-back FIFO.
// Write-backs always drain into the array before a later request is accepted.
module l1_backing_mem #(
    parameter int DEPTH    = 128,
    parameter int WB_DEPTH = 4,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [8:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        cpu_write_back,
    input  logic [8:0]  address_out_mem_cpu,
    input  logic [31:0] data_out_mem_cpu,
    input  logic        bus_write_back,
    input  logic [8:0]  address_out_mem_bus,
    input  logic [31:0] data_out_mem_bus,
    output logic        wb_full,
    output logic        wb_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] WB_DEPTH_C = CW'(WB_DEPTH);
    localparam logic [2:0]    WAIT_INIT  = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] fifo_addr_q [WB_DEPTH];
    logic [31:0]   fifo_data_q [WB_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [2:0]    wait_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          ready_q;
    logic [31:0]   rdata_q;

    logic          cpu_acc;
    logic          bus_acc;
    logic          pop;
    logic          accept;
    logic [PW-1:0] bus_slot;
    logic [AW-1:0] rd_idx;
    logic [31:0]   read_word;
    logic          unused_ok;

    // Free slots are judged before this cycle's pop, CPU entry first.
    always_comb begin
        cpu_acc  = cpu_write_back && (count_q < WB_DEPTH_C);
        bus_acc  = bus_write_back && ((count_q + CW'(cpu_acc)) < WB_DEPTH_C);
        bus_slot = wr_ptr_q + PW'(cpu_acc);
        pop      = (count_q != '0);
        accept   = (state_q == S_IDLE) && mem_valid && !pop
                   && !cpu_write_back && !bus_write_back;
        count_d  = count_q + CW'(cpu_acc) + CW'(bus_acc) - CW'(pop);
    end

    assign rd_idx    = (state_q == S_IDLE) ? mem_addr[AW+1:2] : addr_q;
    assign read_word = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(cpu_acc) + PW'(bus_acc);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_d;
            if ((cpu_write_back && !cpu_acc) || (bus_write_back && !bus_acc)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_acc) begin
            fifo_addr_q[wr_ptr_q] <= address_out_mem_cpu[AW+1:2];
            fifo_data_q[wr_ptr_q] <= data_out_mem_cpu;
        end
        if (bus_acc) begin
            fifo_addr_q[bus_slot] <= address_out_mem_bus[AW+1:2];
            fifo_data_q[bus_slot] <= data_out_mem_bus;
        end
    end

    // A drain landing on the same edge as a store is the later write and wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_RESP) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) begin
                        mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
            if (pop) begin
                mem_q[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= mem_addr[AW+1:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        wait_q  <= WAIT_INIT;
                        if (RD_LAT == 1) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= read_word;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= read_word;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_RESP:  state_q <= S_GAP;
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign wb_full     = (WB_DEPTH_C - count_q) < CW'(2);
    assign wb_overflow = overflow_q;

    assign unused_ok = ^{mem_instr, mem_addr[1:0],
                         address_out_mem_cpu[1:0], address_out_mem_bus[1:0]};

endmodule

// File: tb/tb_l1_backing_mem.sv
// Directed bench for l1_backing_mem: one RD_LAT=1 instance and one RD_LAT=4
// instance sharing stimulus, each with its own request valid.
module tb_l1_backing_mem;
    logic        clk;
    logic        reset;
    logic        valid1;
    logic        valid4;
    logic        memInstr;
    logic [8:0]  memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        cpuWb;
    logic [8:0]  cpuAddr;
    logic [31:0] cpuData;
    logic        busWb;
    logic [8:0]  busAddr;
    logic [31:0] busData;

    logic        ready1, ready4;
    logic [31:0] rdata1, rdata4;
    logic        full1, full4;
    logic        ovf1, ovf4;

    int compareCount = 0;
    int mismatchCount = 0;

    l1_backing_mem #(.DEPTH(128), .WB_DEPTH(4), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(valid1), .mem_instr(memInstr), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_wstrb(memWstrb),
        .mem_ready(ready1), .mem_rdata(rdata1),
        .cpu_write_back(cpuWb), .address_out_mem_cpu(cpuAddr), .data_out_mem_cpu(cpuData),
        .bus_write_back(busWb), .address_out_mem_bus(busAddr), .data_out_mem_bus(busData),
        .wb_full(full1), .wb_overflow(ovf1)
    );

    l1_backing_mem #(.DEPTH(128), .WB_DEPTH(4), .RD_LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .mem_valid(valid4), .mem_instr(memInstr), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_wstrb(memWstrb),
        .mem_ready(ready4), .mem_rdata(rdata4),
        .cpu_write_back(cpuWb), .address_out_mem_cpu(cpuAddr), .data_out_mem_cpu(cpuData),
        .bus_write_back(busWb), .address_out_mem_bus(busAddr), .data_out_mem_bus(busData),
        .wb_full(full4), .wb_overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cEn, input logic [8:0] cA, input logic [31:0] cD,
                                 input logic bEn, input logic [8:0] bA, input logic [31:0] bD);
        cpuWb = cEn; cpuAddr = cA; cpuData = cD;
        busWb = bEn; busAddr = bA; busData = bD;
        tick();
        cpuWb = 1'b0;
        busWb = 1'b0;
    endtask

    // Issue one request on the selected instance and check data, latency and pulse width.
    task automatic doRequest(input string tag, input int sel, input logic [8:0] addr,
                             input logic [3:0] strb, input logic [31:0] wdata,
                             input logic instr, input logic [31:0] expData, input int expTicks);
        int ticks;
        logic got;
        logic [31:0] data;
        memAddr = addr; memWstrb = strb; memWdata = wdata; memInstr = instr;
        if (sel == 0) valid1 = 1'b1; else valid4 = 1'b1;
        ticks = 0;
        got = 1'b0;
        data = '0;
        while (!got && ticks < 30) begin
            tick();
            ticks++;
            if ((sel == 0) ? ready1 : ready4) begin
                got = 1'b1;
                data = (sel == 0) ? rdata1 : rdata4;
            end
        end
        valid1 = 1'b0;
        valid4 = 1'b0;
        memInstr = 1'b0;
        checkOutput({tag, "_seen"}, 32'(got), 32'd1);
        checkOutput({tag, "_data"}, data, expData);
        checkOutput({tag, "_lat"}, 32'(ticks), 32'(expTicks));
        tick();
        checkOutput({tag, "_pulse"}, 32'((sel == 0) ? ready1 : ready4), 32'd0);
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0]  ovAddr [6];
        logic [31:0] ovData [6];
        logic        expFull [3];
        logic        expOvf [3];
        int          ticks;
        logic        got;
        logic [31:0] data;
        logic        sawReady;

        reset = 1'b1;
        valid1 = 1'b0; valid4 = 1'b0; memInstr = 1'b0;
        memAddr = '0; memWdata = '0; memWstrb = '0;
        cpuWb = 1'b0; cpuAddr = '0; cpuData = '0;
        busWb = 1'b0; busAddr = '0; busData = '0;

        repeat (3) tick();
        checkOutput("rst_ready", 32'(ready1), 32'd0);
        checkOutput("rst_rdata", rdata1, 32'd0);
        checkOutput("rst_full", 32'(full1), 32'd0);
        checkOutput("rst_ovf", 32'(ovf1), 32'd0);
        checkOutput("rst_ready4", 32'(ready4), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rel_full", 32'(full1), 32'd0);

        applyStimulus(1'b1, 9'h008, 32'h0000A103, 1'b1, 9'h1FC, 32'h11223344);
        repeat (3) tick();
        doRequest("fetch", 0, 9'h008, 4'b0000, 32'h0, 1'b1, 32'h0000A103, 1);
        doRequest("fetch4", 1, 9'h008, 4'b0000, 32'h0, 1'b1, 32'h0000A103, 4);

        doRequest("st_lo", 0, 9'h1FC, 4'b0011, 32'hAABBCCDD, 1'b0, 32'h11223344, 1);
        doRequest("rd_lo", 0, 9'h1FC, 4'b0000, 32'h0, 1'b0, 32'h1122CCDD, 1);
        doRequest("st_hi", 0, 9'h1FC, 4'b1100, 32'h55667788, 1'b0, 32'h1122CCDD, 1);
        doRequest("rd_hi", 0, 9'h1FC, 4'b0000, 32'h0, 1'b0, 32'h5566CCDD, 1);

        // Read pending while both write-backs are pushed in the same cycle.
        memAddr = 9'h010; memWstrb = 4'b0000; memWdata = '0;
        valid1 = 1'b1;
        applyStimulus(1'b1, 9'h010, 32'hCAFE0001, 1'b1, 9'h020, 32'hBEEF0002);
        ticks = 1;
        checkOutput("ord_early", 32'(ready1), 32'd0);
        got = 1'b0;
        data = '0;
        while (!got && ticks < 30) begin
            tick();
            ticks++;
            if (ready1) begin
                got = 1'b1;
                data = rdata1;
            end
        end
        valid1 = 1'b0;
        checkOutput("ord_data", data, 32'hCAFE0001);
        checkOutput("ord_lat", 32'(ticks), 32'd4);
        repeat (2) tick();
        doRequest("ord_bus", 0, 9'h020, 4'b0000, 32'h0, 1'b0, 32'hBEEF0002, 1);

        applyStimulus(1'b1, 9'h054, 32'h0BAD0BAD, 1'b0, 9'h0, 32'h0);
        repeat (2) tick();
        ovAddr = '{9'h040, 9'h044, 9'h048, 9'h04C, 9'h050, 9'h054};
        ovData = '{32'hD0000001, 32'hD0000002, 32'hD0000003,
                   32'hD0000004, 32'hD0000005, 32'hD0000006};
        expFull = '{1'b0, 1'b1, 1'b1};
        expOvf  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ovAddr[2*i], ovData[2*i], 1'b1, ovAddr[2*i+1], ovData[2*i+1]);
            checkOutput($sformatf("ovf_full%0d", i), 32'(full1), 32'(expFull[i]));
            checkOutput($sformatf("ovf_flag%0d", i), 32'(ovf1), 32'(expOvf[i]));
        end
        tick();
        checkOutput("ovf_full_drain", 32'(full1), 32'd0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            doRequest($sformatf("ovf_rd%0d", i), 0, ovAddr[i], 4'b0000, 32'h0, 1'b0, ovData[i], 1);
        end
        doRequest("ovf_drop", 0, 9'h054, 4'b0000, 32'h0, 1'b0, 32'h0BAD0BAD, 1);
        checkOutput("ovf_sticky", 32'(ovf1), 32'd1);

        applyStimulus(1'b1, 9'h060, 32'h12345678, 1'b1, 9'h064, 32'h0A0A0A0A);
        repeat (3) tick();
        memAddr = 9'h060; memWstrb = 4'b1111; memWdata = 32'hFFFFFFFF;
        valid4 = 1'b1;
        tick();
        applyStimulus(1'b1, 9'h064, 32'hDEADBEEF, 1'b0, 9'h0, 32'h0);
        reset = 1'b1;
        valid4 = 1'b0;
        sawReady = ready4;
        tick();
        sawReady = sawReady | ready4;
        tick();
        sawReady = sawReady | ready4;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sawReady = sawReady | ready4;
        end
        checkOutput("rstw_no_ready", 32'(sawReady), 32'd0);
        checkOutput("rstw_full", 32'(full4), 32'd0);
        checkOutput("rstw_ovf", 32'(ovf4), 32'd0);
        doRequest("rstw_word", 1, 9'h060, 4'b0000, 32'h0, 1'b0, 32'h12345678, 4);
        doRequest("rstw_wb_lost", 1, 9'h064, 4'b0000, 32'h0, 1'b0, 32'h0A0A0A0A, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
